gray_seq_ctrl: RTL and testbench

Sequencer that steps a binary count from 0 to a programmable limit and presents each value as a registered Gray code, one code per accepted step. It sits in front of the `bin_to_gray` encoder in the en_de_code library. It drives encoder-position emulators, Gray-coded address generators and pointer stimulus, and provides a start/stop/done handshake plus one-shot or looping operation.

---
 rtl/gray_seq_pkg.sv | 13 +
 rtl/bin_to_gray.sv | 11 +
 rtl/gray_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_gray_seq_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_seq_pkg.sv
// Shared types and constants for the Gray-code sequencer.
package gray_seq_pkg;

   localparam int unsigned GRAY_SEQ_NMIN = 2;
   localparam int unsigned GRAY_SEQ_NMAX = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } gray_seq_state_e;

endpackage

// File: rtl/bin_to_gray.sv
// Combinational binary-to-Gray encoder from the en_de_code library.
module bin_to_gray #(
   parameter int unsigned n = 4
) (
   input  logic [n-1:0] bin,
   output logic [n-1:0] gray
);

   assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_seq_ctrl.sv
// Steps a binary count 0..limit and emits each value as a registered Gray code.
// Optional adjacency checker enabled by defining GRAY_SEQ_CHECK_EN.
module gray_seq_ctrl
   import gray_seq_pkg::*;
#(
   parameter int unsigned n = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         stop,
   input  logic         loop,
   input  logic [n-1:0] limit,
   input  logic         step_en,
   output logic [n-1:0] gray_out,
   output logic         gray_valid,
   output logic         busy,
   output logic         done,
   output logic         wrap,
   output logic         err
);

   if (n < GRAY_SEQ_NMIN || n > GRAY_SEQ_NMAX) begin : g_bad_n
      $error("gray_seq_ctrl: n out of range");
   end

   localparam logic [n-1:0] CntOne = {{(n-1){1'b0}}, 1'b1};

   gray_seq_state_e state_q, state_d;
   logic [n-1:0]    cnt_q, cnt_d;
   logic [n-1:0]    limit_q, limit_d;
   logic            loop_q, loop_d;
   logic            wrap_pend_q, wrap_pend_d;
   logic [n-1:0]    gray_q, gray_d;
   logic            valid_q, wrap_q;
   logic [n-1:0]    gray_w;
   logic            emit;
   logic            start_acc;

   bin_to_gray #(.n(n)) u_bin_to_gray (
      .bin  (cnt_q),
      .gray (gray_w)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      limit_d     = limit_q;
      loop_d      = loop_q;
      wrap_pend_d = wrap_pend_q;
      emit        = 1'b0;
      start_acc   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               start_acc   = 1'b1;
               limit_d     = limit;
               loop_d      = loop;
               cnt_d       = '0;
               wrap_pend_d = 1'b0;
               state_d     = RUN;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = DONE;
            end else if (step_en) begin
               emit        = 1'b1;
               // Flag the next emission as a wrap when this one ends a lap.
               wrap_pend_d = loop_q && (cnt_q >= limit_q);
               if (cnt_q < limit_q) begin
                  cnt_d = cnt_q + CntOne;
               end else if (loop_q) begin
                  cnt_d = '0;
               end else begin
                  state_d = DONE;
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign gray_d = emit ? gray_w : gray_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         limit_q     <= '0;
         loop_q      <= 1'b0;
         wrap_pend_q <= 1'b0;
         gray_q      <= '0;
         valid_q     <= 1'b0;
         wrap_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         limit_q     <= limit_d;
         loop_q      <= loop_d;
         wrap_pend_q <= wrap_pend_d;
         gray_q      <= gray_d;
         valid_q     <= emit;
         wrap_q      <= emit && wrap_pend_q;
      end
   end

`ifdef GRAY_SEQ_CHECK_EN
   logic [n-1:0] prev_q, prev_d;
   logic         first_q, first_d;
   logic         err_q, err_d;

   always_comb begin
      prev_d  = prev_q;
      first_d = first_q;
      err_d   = err_q;
      if (start_acc) begin
         first_d = 1'b1;
         err_d   = 1'b0;
      end else if (emit) begin
         prev_d  = gray_w;
         first_d = 1'b0;
         // First code of a run and post-wrap codes have no valid predecessor.
         if (!first_q && !wrap_pend_q && ($countones(prev_q ^ gray_w) != 1)) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q  <= '0;
         first_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         prev_q  <= prev_d;
         first_q <= first_d;
         err_q   <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign gray_out   = gray_q;
   assign gray_valid = valid_q;
   assign busy       = (state_q == RUN);
   assign done       = (state_q == DONE);
   assign wrap       = wrap_q;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Self-checking bench for gray_seq_ctrl (n=4): emission-index model plus directed literal checks.
module tb_gray_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, stop, loop, step_en;
   logic [3:0] limit;
   logic [3:0] gray_out;
   logic       gray_valid, busy, done, wrap, err;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int done_seen = 0;
   logic chk_en;

   // Model: a run is a sequence of emissions; the k-th emitted count is k mod (limit+1).
   logic m_run, m_in_done;
   int   m_idx, m_lim;
   logic m_loop;
   logic [3:0] e_gray;
   logic e_valid, e_wrap;

   int log_gray[$];
   int log_wrap[$];
   int log_done[$];
   int log_cyc[$];

   gray_seq_ctrl #(.n(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .stop       (stop),
      .loop       (loop),
      .limit      (limit),
      .step_en    (step_en),
      .gray_out   (gray_out),
      .gray_valid (gray_valid),
      .busy       (busy),
      .done       (done),
      .wrap       (wrap),
      .err        (err)
   );

   always #5 clk = ~clk;

   function automatic int code_of(input int idx, input int lim);
      return idx % (lim + 1);
   endfunction

   function automatic int to_gray(input int c);
      return c ^ (c >> 1);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run     <= 1'b0;
         m_in_done <= 1'b0;
         m_idx     <= 0;
         m_lim     <= 0;
         m_loop    <= 1'b0;
         e_gray    <= '0;
         e_valid   <= 1'b0;
         e_wrap    <= 1'b0;
      end else begin
         e_valid <= 1'b0;
         e_wrap  <= 1'b0;
         if (m_in_done) begin
            m_in_done <= 1'b0;
         end else if (!m_run) begin
            if (start) begin
               m_run  <= 1'b1;
               m_lim  <= int'(limit);
               m_loop <= loop;
               m_idx  <= 0;
            end
         end else if (stop) begin
            m_run     <= 1'b0;
            m_in_done <= 1'b1;
         end else if (step_en) begin
            e_gray  <= 4'(to_gray(code_of(m_idx, m_lim)));
            e_valid <= 1'b1;
            e_wrap  <= m_loop && (m_idx > 0) && (code_of(m_idx, m_lim) == 0);
            m_idx   <= m_idx + 1;
            if (!m_loop && (m_idx == m_lim)) begin
               m_run     <= 1'b0;
               m_in_done <= 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("outputs{gray,valid,busy,done,wrap,err}",
               int'({gray_out, gray_valid, busy, done, wrap, err}),
               int'({e_gray, e_valid, m_run, m_in_done, e_wrap, 1'b0}));
      end
      if (done) done_seen++;
      if (gray_valid) begin
         log_gray.push_back(int'(gray_out));
         log_wrap.push_back(int'(wrap));
         log_done.push_back(int'(done));
         log_cyc.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      log_gray.delete();
      log_wrap.delete();
      log_done.delete();
      log_cyc.delete();
      done_seen = 0;
   endtask

   task automatic begin_run(input int lim, input logic lp);
      start   = 1'b1;
      limit   = 4'(lim);
      loop    = lp;
      step_en = 1'b0;
      tick();
      start = 1'b0;
   endtask

   task automatic end_run();
      step_en = 1'b0;
      stop    = 1'b1;
      tick();
      stop = 1'b0;
      tick();
      tick();
   endtask

   task automatic check_codes(input string name, input int exp_g[], input int exp_w[]);
      check({name, "_count"}, log_gray.size(), exp_g.size());
      for (int i = 0; i < exp_g.size() && i < log_gray.size(); i++) begin
         check($sformatf("%s_code%0d", name, i), log_gray[i], exp_g[i]);
         check($sformatf("%s_wrap%0d", name, i), log_wrap[i], exp_w[i]);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0; step_en = 1'b0; limit = '0;
      chk_en = 1'b1;
      repeat (3) tick();
      check("reset_outputs", int'({gray_out, gray_valid, busy, done, wrap, err}), 0);
      rst_n = 1'b1;
      tick();

      // 1: async reset mid-run, then one-shot limit 3
      begin_run(3, 1'b1);
      step_en = 1'b1;
      repeat (3) tick();
      #2 rst_n = 1'b0;
      #1 check("midrun_reset_outputs", int'({gray_out, gray_valid, busy, done, wrap, err}), 0);
      tick();
      rst_n = 1'b1;
      tick();
      check("post_reset_idle_busy", int'(busy), 0);
      clear_log();
      start = 1'b1; limit = 4'd3; loop = 1'b0; step_en = 1'b1;
      tick();
      start = 1'b0;
      repeat (6) tick();
      step_en = 1'b0;
      check_codes("s1", '{0, 1, 3, 2}, '{0, 0, 0, 0});
      if (log_done.size() == 4) begin
         check("s1_done_with_last", log_done[3], 1);
         check("s1_no_early_done", log_done[2], 0);
      end
      check("s1_done_once", done_seen, 1);

      // 2: step_en toggling, limit 5
      clear_log();
      begin_run(5, 1'b0);
      for (int i = 0; i < 14; i++) begin
         step_en = (i % 2 == 0);
         tick();
      end
      step_en = 1'b0;
      check_codes("s2", '{0, 1, 3, 2, 6, 7}, '{0, 0, 0, 0, 0, 0});
      for (int i = 1; i < log_cyc.size(); i++)
         check($sformatf("s2_spacing%0d", i), log_cyc[i] - log_cyc[i-1], 2);
      tick();

      // 3: looping, limit 2
      clear_log();
      begin_run(2, 1'b1);
      step_en = 1'b1;
      repeat (7) tick();
      step_en = 1'b0;
      tick();
      check_codes("s3", '{0, 1, 3, 0, 1, 3, 0}, '{0, 0, 0, 1, 0, 0, 1});
      check("s3_no_done", done_seen, 0);
      check("s3_busy", int'(busy), 1);
      end_run();

      // 4: full-range natural rollover
      clear_log();
      begin_run(15, 1'b1);
      step_en = 1'b1;
      repeat (20) tick();
      step_en = 1'b0;
      tick();
      check("s4_count", log_gray.size(), 20);
      if (log_gray.size() >= 17) begin
         check("s4_code15", log_gray[15], 8);
         check("s4_wrap15", log_wrap[15], 0);
         check("s4_code16", log_gray[16], 0);
         check("s4_wrap16", log_wrap[16], 1);
      end
      check("s4_err", int'(err), 0);
      end_run();

      // 5a: stop after three codes
      clear_log();
      begin_run(9, 1'b0);
      step_en = 1'b1;
      repeat (3) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0; step_en = 1'b0;
      check("s5_stop_done", int'(done), 1);
      check("s5_stop_valid", int'(gray_valid), 0);
      check("s5_stop_gray", int'(gray_out), 3);
      tick();
      tick();
      // 5b: limit 0 one-shot
      clear_log();
      begin_run(0, 1'b0);
      step_en = 1'b1;
      repeat (3) tick();
      step_en = 1'b0;
      check_codes("s5b", '{0}, '{0});
      if (log_done.size() == 1) check("s5b_done", log_done[0], 1);
      // 5c: start and stop together in IDLE
      start = 1'b1; stop = 1'b1; limit = 4'd4; loop = 1'b0;
      tick();
      start = 1'b0; stop = 1'b0;
      check("s5c_start_wins", int'(busy), 1);
      end_run();

`ifdef GRAY_SEQ_CHECK_EN
      // 6: corrupt the count to force a non-adjacent emission
      chk_en = 1'b0;
      begin_run(15, 1'b0);
      step_en = 1'b1;
      repeat (3) tick();
      force dut.cnt_q = 4'd6;
      tick();
      release dut.cnt_q;
      check("s6_err_set", int'(err), 1);
      end_run();
      check("s6_err_held", int'(err), 1);
      begin_run(3, 1'b0);
      check("s6_err_clear", int'(err), 0);
      end_run();
      chk_en = 1'b1;
`else
      check("s6_err_tied", int'(err), 0);
`endif

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         start   = ($urandom_range(0, 3) == 0);
         stop    = ($urandom_range(0, 19) == 0);
         step_en = ($urandom_range(0, 9) < 7);
         loop    = $urandom_range(0, 1) == 1;
         limit   = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 6));
         if ($urandom_range(0, 499) == 0) begin
            #1 rst_n = 1'b0;
            #2 rst_n = 1'b1;
         end
         tick();
      end
      start = 1'b0; stop = 1'b0; step_en = 1'b0;
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
